stl_rr_arb_pipe: RTL and testbench

N-requester round-robin arbiter that shares one downstream valid/ready channel between several valid/ready producers. It supports multi-beat packets: a grant is held from the first accepted beat until the accepted beat carrying last=1. The output side has an optional one-entry zero-latency skid buffer, so a stalled consumer does not add a bubble. The block sits in front of shared datapath resources (pipes, FIFOs, memory ports) that several clients must reach through a single channel.

---
 rtl/stl_rr_arb_pipe.sv | 151 +++++++++++++++
 tb/tb_stl_rr_arb_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stl_rr_arb_pipe.sv
// Round-robin N:1 valid/ready arbiter with packet lock
// and an optional one-entry skid buffer on the output.
module stl_rr_arb_pipe #(
  parameter int  REQ_N   = 4,
  parameter int  DATA_W  = 32,
  parameter int  PIPE_EN = 1,
  localparam int ID_W    = $clog2(REQ_N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ_N-1:0]        up_vld_i,
  output logic [REQ_N-1:0]        up_rdy_o,
  input  logic [REQ_N*DATA_W-1:0] up_dat_i,
  input  logic [REQ_N-1:0]        up_last_i,
  output logic                    dn_vld_o,
  input  logic                    dn_rdy_i,
  output logic [DATA_W-1:0]       dn_dat_o,
  output logic                    dn_last_o,
  output logic [ID_W-1:0]         dn_id_o,
  output logic                    lock_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   arb_id, idx, g;
  logic              arb_hit, g_hit, g_vld;
  logic              g_last, g_rdy, acc;
  logic [DATA_W-1:0] g_dat;
  logic [DATA_W-1:0] dat_arr [REQ_N];

  // Unpack the flat payload bus per requester
  always_comb begin
    for (int k = 0; k < REQ_N; k++) begin
      dat_arr[k] = up_dat_i[k*DATA_W +: DATA_W];
    end
  end

  // Search for the first valid requester after ptr
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = '0;
    idx     = '0;
    for (int i = 1; i <= REQ_N; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % REQ_N);
      if (!arb_hit && up_vld_i[idx]) begin
        arb_hit = 1'b1;
        arb_id  = idx;
      end
    end
  end

  assign g      = (state_q == LOCK) ? lock_id_q : arb_id;
  assign g_hit  = ~rst & ((state_q == LOCK) | arb_hit);
  assign g_vld  = g_hit & up_vld_i[g];
  assign g_dat  = dat_arr[g];
  assign g_last = up_last_i[g];
  assign acc    = g_vld & g_rdy;
  assign lock_o = ~rst & (state_q == LOCK);

  // Only the granted requester sees ready
  always_comb begin
    up_rdy_o = '0;
    if (g_hit) up_rdy_o[g] = g_rdy;
  end

  // Packet lock and pointer update on accepted beats
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (g_last) begin
            ptr_d = g;
          end else begin
            state_d   = LOCK;
            lock_id_d = g;
          end
        end
        LOCK: begin
          if (g_last) begin
            state_d = IDLE;
            ptr_d   = lock_id_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(REQ_N - 1);
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  if (PIPE_EN != 0) begin : g_pipe
    logic              buf_vld;
    logic [DATA_W-1:0] buf_dat;
    logic              buf_last;
    logic [ID_W-1:0]   buf_id;
    logic              buf_wr;

    assign g_rdy  = dn_rdy_i | ~buf_vld;
    assign buf_wr = acc & ((~buf_vld & ~dn_rdy_i)
                         | (buf_vld & dn_rdy_i));

    assign dn_vld_o  = ~rst & (buf_vld | g_vld);
    assign dn_dat_o  = buf_vld ? buf_dat  : g_dat;
    assign dn_last_o = buf_vld ? buf_last : g_last;
    assign dn_id_o   = buf_vld ? buf_id   : g;

    // Skid entry occupancy
    always_ff @(posedge clk) begin
      if (rst) begin
        buf_vld <= 1'b0;
      end else if (buf_wr) begin
        buf_vld <= 1'b1;
      end else if (dn_vld_o & dn_rdy_i) begin
        buf_vld <= 1'b0;
      end
    end

    // Skid entry payload
    always_ff @(posedge clk) begin
      if (buf_wr) begin
        buf_dat  <= g_dat;
        buf_last <= g_last;
        buf_id   <= g;
      end
    end
  end else begin : g_pass
    assign g_rdy     = dn_rdy_i;
    assign dn_vld_o  = g_vld;
    assign dn_dat_o  = g_dat;
    assign dn_last_o = g_last;
    assign dn_id_o   = g;
  end

endmodule

// File: tb/tb_stl_rr_arb_pipe.sv
// Bench for stl_rr_arb_pipe: queue-fed requesters,
// scoreboard on the downstream port, directed checks.
module tb_stl_rr_arb_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   up_vld_i = '0;
  logic [3:0]   up_rdy_o;
  logic [127:0] up_dat_i = '0;
  logic [3:0]   up_last_i = '0;
  logic         dn_vld_o;
  logic         dn_rdy_i;
  logic [31:0]  dn_dat_o;
  logic         dn_last_o;
  logic [1:0]   dn_id_o;
  logic         lock_o;

  logic [3:0]   p0_vld;
  logic [3:0]   p0_rdy_up;
  logic [127:0] p0_dat;
  logic [3:0]   p0_last;
  logic         p0_dn_vld;
  logic         p0_dn_rdy;
  logic [31:0]  p0_dn_dat;
  logic         p0_dn_last;
  logic [1:0]   p0_dn_id;
  logic         p0_lock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] src_q [4][$];
  logic [34:0] exp_q [$];
  logic [3:0]  acc_r = '0;

  stl_rr_arb_pipe #(.REQ_N(4), .DATA_W(32), .PIPE_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .up_vld_i(up_vld_i), .up_rdy_o(up_rdy_o),
    .up_dat_i(up_dat_i), .up_last_i(up_last_i),
    .dn_vld_o(dn_vld_o), .dn_rdy_i(dn_rdy_i),
    .dn_dat_o(dn_dat_o), .dn_last_o(dn_last_o),
    .dn_id_o(dn_id_o), .lock_o(lock_o)
  );

  stl_rr_arb_pipe #(.REQ_N(4), .DATA_W(32), .PIPE_EN(0)) u_p0 (
    .clk(clk), .rst(rst),
    .up_vld_i(p0_vld), .up_rdy_o(p0_rdy_up),
    .up_dat_i(p0_dat), .up_last_i(p0_last),
    .dn_vld_o(p0_dn_vld), .dn_rdy_i(p0_dn_rdy),
    .dn_dat_o(p0_dn_dat), .dn_last_o(p0_dn_last),
    .dn_id_o(p0_dn_id), .lock_o(p0_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input int k, input logic [31:0] d,
                      input logic l);
    src_q[k].push_back({l, d});
  endtask

  task automatic expb(input logic [1:0] id,
                      input logic [31:0] d, input logic l);
    exp_q.push_back({id, l, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit src_empty();
    return src_q[0].size() == 0 && src_q[1].size() == 0 &&
           src_q[2].size() == 0 && src_q[3].size() == 0;
  endfunction

  task automatic wait_drain(input string nm);
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0 && src_empty()) break;
      @(negedge clk);
      #1;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Requester models: record handshakes mid-cycle
  always @(negedge clk) acc_r = up_vld_i & up_rdy_o;

  // Requester models: retire accepted beat, present next
  always @(posedge clk) begin
    logic [32:0] h;
    #2;
    for (int k = 0; k < 4; k++) begin
      if (acc_r[k] && src_q[k].size() > 0)
        void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        h = src_q[k][0];
        up_vld_i[k]           = 1'b1;
        up_dat_i[k*32 +: 32]  = h[31:0];
        up_last_i[k]          = h[32];
      end else begin
        up_vld_i[k]  = 1'b0;
        up_last_i[k] = 1'b0;
      end
    end
  end

  // Scoreboard monitor on the downstream handshake
  always @(negedge clk) begin
    if (!rst && dn_vld_o && dn_rdy_i) begin
      if (exp_q.size() == 0) begin
        chk("dn_unexpected", {29'd0, dn_id_o, dn_last_o, dn_dat_o},
            64'h7_FFFF_FFFF);
      end else begin
        chk("dn_beat", {29'd0, dn_id_o, dn_last_o, dn_dat_o},
            {29'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    dn_rdy_i  = 1'b1;
    p0_vld    = 4'b0010;
    p0_last   = 4'b1111;
    p0_dat    = {32'h3333_3333, 32'h2222_2222,
                 32'h1111_1111, 32'h0000_0000};
    p0_dn_rdy = 1'b1;

    // Round robin over four always-valid requesters
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++)
        beat(k, 32'h100 * k + j, 1'b1);
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++)
        expb(2'(k), 32'h100 * k + j, 1'b1);

    @(negedge clk);
    chk("rst_up_rdy", 64'(up_rdy_o), 64'd0);
    chk("rst_dn_vld", 64'(dn_vld_o), 64'd0);
    chk("rst_lock", 64'(lock_o), 64'd0);
    chk("rst_p0_rdy", 64'(p0_rdy_up), 64'd0);

    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_no_bubble", 64'(dn_vld_o), 64'd1);
    end
    @(negedge clk);
    chk("rr_idle_after", 64'(dn_vld_o), 64'd0);
    wait_drain("rr_drain");

    // Move ptr to 1, then a 3-beat packet from requester 2
    tick();
    beat(1, 32'h1F, 1'b1);
    expb(2'd1, 32'h1F, 1'b1);
    wait_drain("ptr1_drain");
    tick();
    beat(2, 32'hA, 1'b0);
    beat(2, 32'hB, 1'b0);
    beat(2, 32'hC, 1'b1);
    beat(0, 32'hD0, 1'b1);
    beat(3, 32'h3E0, 1'b1);
    expb(2'd2, 32'hA, 1'b0);
    expb(2'd2, 32'hB, 1'b0);
    expb(2'd2, 32'hC, 1'b1);
    expb(2'd3, 32'h3E0, 1'b1);
    expb(2'd0, 32'hD0, 1'b1);
    @(negedge clk);
    chk("pkt_c1_lock", 64'(lock_o), 64'd0);
    @(negedge clk);
    chk("pkt_c2_lock", 64'(lock_o), 64'd1);
    chk("pkt_c2_rdy", 64'(up_rdy_o), 64'b0100);
    @(negedge clk);
    chk("pkt_c3_lock", 64'(lock_o), 64'd1);
    @(negedge clk);
    chk("pkt_c4_lock", 64'(lock_o), 64'd0);
    chk("pkt_c4_id", 64'(dn_id_o), 64'd3);
    wait_drain("pkt_drain");

    // Stall three cycles with requester 1 presenting D1, D2
    tick();
    dn_rdy_i = 1'b0;
    beat(1, 32'hD1, 1'b1);
    beat(1, 32'hD2, 1'b1);
    expb(2'd1, 32'hD1, 1'b1);
    expb(2'd1, 32'hD2, 1'b1);
    @(negedge clk);
    chk("skid_c1_rdy", 64'(up_rdy_o), 64'b0010);
    chk("skid_c1_vld", 64'(dn_vld_o), 64'd1);
    chk("skid_c1_dat", 64'(dn_dat_o), 64'hD1);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk("skid_hold_rdy", 64'(up_rdy_o), 64'd0);
      chk("skid_hold_vld", 64'(dn_vld_o), 64'd1);
      chk("skid_hold_dat", 64'(dn_dat_o), 64'hD1);
    end
    tick();
    dn_rdy_i = 1'b1;
    @(negedge clk);
    chk("refill_dat", 64'(dn_dat_o), 64'hD1);
    chk("refill_rdy", 64'(up_rdy_o), 64'b0010);
    @(negedge clk);
    chk("refill_buf_vld", 64'(dn_vld_o), 64'd1);
    chk("refill_buf_dat", 64'(dn_dat_o), 64'hD2);
    chk("refill_no_grant", 64'(up_rdy_o), 64'd0);
    @(negedge clk);
    chk("refill_empty", 64'(dn_vld_o), 64'd0);
    wait_drain("skid_drain");

    // Reset after beat 1 of a 4-beat packet from requester 0
    tick();
    beat(0, 32'h40, 1'b0);
    beat(0, 32'h41, 1'b0);
    beat(0, 32'h42, 1'b0);
    beat(0, 32'h43, 1'b1);
    expb(2'd0, 32'h40, 1'b0);
    @(negedge clk);
    chk("mid_c1_id", 64'(dn_id_o), 64'd0);
    chk("mid_c1_lock", 64'(lock_o), 64'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 64'(up_rdy_o), 64'd0);
    chk("mid_rst_vld", 64'(dn_vld_o), 64'd0);
    chk("mid_rst_lock", 64'(lock_o), 64'd0);
    tick();
    rst = 1'b0;
    beat(3, 32'h3A, 1'b1);
    expb(2'd0, 32'h41, 1'b0);
    expb(2'd0, 32'h42, 1'b0);
    expb(2'd0, 32'h43, 1'b1);
    expb(2'd3, 32'h3A, 1'b1);
    @(negedge clk);
    chk("post_rst_lock", 64'(lock_o), 64'd0);
    chk("post_rst_vld", 64'(dn_vld_o), 64'd1);
    chk("post_rst_id", 64'(dn_id_o), 64'd0);
    wait_drain("post_rst_drain");

    // Pass-through variant: ready follows dn_rdy each cycle
    for (int i = 0; i < 6; i++) begin
      tick();
      p0_dn_rdy = (i % 2 == 0);
      @(negedge clk);
      chk("p0_rdy", 64'(p0_rdy_up),
          64'({2'b00, p0_dn_rdy, 1'b0}));
      chk("p0_vld", 64'(p0_dn_vld), 64'd1);
      chk("p0_id", 64'(p0_dn_id), 64'd1);
      chk("p0_dat", 64'(p0_dn_dat), 64'h1111_1111);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
